// File: rtl/serial_shifter_rev.sv
// -----------------------------------------------------------------------------
// serial_shifter_rev
//
// Multi-cycle 16-bit shifter covering the shift directions that the
// single-cycle ALU shifter does not: logical right (SRL), arithmetic left with
// overflow detection (SLA) and rotate left (ROL). An operand is captured on a
// start pulse, shifted one position per clock and reported with a one-cycle
// done pulse. The issue logic stalls on busy while an operation is in flight.
//
// Build option:
//   SERIAL_SHIFTER_STEP4_EN  when defined, the SHIFT state moves four bit
//                            positions per clock while at least four remain,
//                            then finishes with single-position steps.
//                            Undefined (default): one position per clock.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   start      in   1      request, sampled only while idle
//   Shift_In   in   WIDTH  operand
//   Shift_Val  in   CNT_W  shift amount (0..WIDTH-1)
//   Mode       in   2      00=SRL, 01=SLA, 10=ROL, 11=illegal
//   busy       out  1      high whenever an operation is in progress
//   done       out  1      single-cycle completion pulse
//   Shift_Out  out  WIDTH  result, held until the next completion
//   ovf        out  1      SLA overflow, updated together with Shift_Out
//   err        out  1      illegal Mode, updated together with Shift_Out
//
// Latency: start sampled in cycle 0 gives done (and a valid Shift_Out) in
// cycle N+1 for N single steps; an illegal Mode or a zero shift amount
// completes in cycle 1.
// -----------------------------------------------------------------------------
module serial_shifter_rev #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Shift_In,
  input  logic [CNT_W-1:0] Shift_Val,
  input  logic [1:0]       Mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Shift_Out,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLA = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  // ---------------------------------------------------------------------------
  // State and working registers
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         mode_q;
  logic               ovf_acc_q;

  // Registered outputs
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   shift_out_q;
  logic               ovf_q;
  logic               err_q;

  // Next values of the working registers for one SHIFT cycle
  logic [WIDTH-1:0]   work_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_acc_d;

  // ---------------------------------------------------------------------------
  // Single-position step candidates
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   srl1_w;
  logic [WIDTH-1:0]   sla1_w;
  logic [WIDTH-1:0]   rol1_w;
  logic               sla1_ovf_w;

  assign srl1_w     = {1'b0, work_q[WIDTH-1:1]};
  assign sla1_w     = {work_q[WIDTH-2:0], 1'b0};
  assign rol1_w     = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
  // Shifting left by one flips the sign whenever the two top bits differ.
  assign sla1_ovf_w = work_q[WIDTH-1] ^ work_q[WIDTH-2];

`ifdef SERIAL_SHIFTER_STEP4_EN
  // ---------------------------------------------------------------------------
  // Four-position step candidates
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   srl4_w;
  logic [WIDTH-1:0]   sla4_w;
  logic [WIDTH-1:0]   rol4_w;
  logic               sla4_ovf_w;
  logic               use_step4_w;

  assign srl4_w     = {4'b0000, work_q[WIDTH-1:4]};
  assign sla4_w     = {work_q[WIDTH-5:0], 4'b0000};
  assign rol4_w     = {work_q[WIDTH-5:0], work_q[WIDTH-1:WIDTH-4]};
  // A 4-position left shift keeps the sign only if the top five bits all
  // equal the current sign bit; any mismatch means the sign changed at some
  // intermediate position, matching four single steps.
  assign sla4_ovf_w = (work_q[WIDTH-1:WIDTH-5] != {5{work_q[WIDTH-1]}});
  assign use_step4_w = (cnt_q >= CNT_W'(4));
`endif

  // ---------------------------------------------------------------------------
  // Step selection
  // ---------------------------------------------------------------------------
  always_comb begin
    work_d    = work_q;
    cnt_d     = cnt_q - CNT_W'(1);
    ovf_acc_d = ovf_acc_q;

`ifdef SERIAL_SHIFTER_STEP4_EN
    if (use_step4_w) begin
      cnt_d = cnt_q - CNT_W'(4);
      case (mode_q)
        MODE_SRL: work_d = srl4_w;
        MODE_SLA: begin
          work_d    = sla4_w;
          ovf_acc_d = ovf_acc_q | sla4_ovf_w;
        end
        MODE_ROL: work_d = rol4_w;
        default:  work_d = work_q;
      endcase
    end else begin
      case (mode_q)
        MODE_SRL: work_d = srl1_w;
        MODE_SLA: begin
          work_d    = sla1_w;
          ovf_acc_d = ovf_acc_q | sla1_ovf_w;
        end
        MODE_ROL: work_d = rol1_w;
        default:  work_d = work_q;
      endcase
    end
`else
    case (mode_q)
      MODE_SRL: work_d = srl1_w;
      MODE_SLA: begin
        work_d    = sla1_w;
        ovf_acc_d = ovf_acc_q | sla1_ovf_w;
      end
      MODE_ROL: work_d = rol1_w;
      // An illegal mode never reaches SHIFT; hold the operand regardless.
      default:  work_d = work_q;
    endcase
`endif
  end

  // ---------------------------------------------------------------------------
  // Controller: state, working registers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_SRL;
      ovf_acc_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_out_q <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // done is a pulse: it is only raised on the edge that enters DONE.
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_q    <= Shift_In;
            cnt_q     <= Shift_Val;
            mode_q    <= Mode;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            if ((Mode == MODE_ILL) || (Shift_Val == '0)) begin
              // Nothing to shift: the operand passes straight through.
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              shift_out_q <= Shift_In;
              ovf_q       <= 1'b0;
              err_q       <= (Mode == MODE_ILL);
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          work_q    <= work_d;
          cnt_q     <= cnt_d;
          ovf_acc_q <= ovf_acc_d;
          if (cnt_d == '0) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            shift_out_q <= work_d;
            // Only SLA ever sets the accumulator, so this is 0 for SRL/ROL.
            ovf_q       <= ovf_acc_d;
            err_q       <= 1'b0;
          end
        end

        ST_DONE: begin
          // Any start seen here is dropped; the requester waits for busy=0.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Shift_Out = shift_out_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_serial_shifter_rev.sv
// -----------------------------------------------------------------------------
// tb_serial_shifter_rev
//
// Self-checking bench for serial_shifter_rev. A table of directed operations
// with hand-computed results is applied one after another; completion latency
// is compared against the expected step count for the active build option
// (SERIAL_SHIFTER_STEP4_EN). Hand-written sequences cover reset during a
// shift and start pulses that must be ignored while busy.
// -----------------------------------------------------------------------------
module tb_serial_shifter_rev;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] Shift_In = 16'h0000;
  logic [3:0]  Shift_Val = 4'd0;
  logic [1:0]  Mode = 2'b00;
  logic        busy;
  logic        done;
  logic [15:0] Shift_Out;
  logic        ovf;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_shifter_rev dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Shift_In  (Shift_In),
    .Shift_Val (Shift_Val),
    .Mode      (Mode),
    .busy      (busy),
    .done      (done),
    .Shift_Out (Shift_Out),
    .ovf       (ovf),
    .err       (err)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] sin;
    logic [3:0]  sval;
    logic [15:0] exp_out;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Cycle in which done is expected, counting the start-sampling cycle as 0.
  function automatic int exp_lat(input logic [1:0] m, input logic [3:0] n);
    if ((m == 2'b11) || (n == 4'd0)) return 1;
`ifdef SERIAL_SHIFTER_STEP4_EN
    return int'(n >> 2) + int'(n & 4'd3) + 1;
`else
    return int'(n) + 1;
`endif
  endfunction

  // Called just after a rising edge (start of cycle 0). Returns just after
  // the rising edge two cycles after done.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] sin,
                        input logic [3:0] sval, input logic [15:0] eo,
                        input logic eov, input logic eer);
    int   lat_e;
    int   cyc;
    logic seen;
    logic busy_ok;
    lat_e     = exp_lat(m, sval);
    Shift_In  = sin;
    Shift_Val = sval;
    Mode      = m;
    start     = 1'b1;
    @(negedge clk);
    check({tag, "_idle_at_start"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    start   = 1'b0;
    cyc     = 1;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat_e));
    check({tag, "_busy_while_working"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_out"}, 32'(Shift_Out), 32'(eo));
    check({tag, "_ovf"}, 32'(ovf), 32'(eov));
    check({tag, "_err"}, 32'(err), 32'(eer));
    $display("op %s mode=%0d in=%h val=%0d -> out=%h ovf=%b err=%b done_cycle=%0d",
             tag, m, sin, sval, Shift_Out, ovf, err, cyc);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_pulse_ends"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   lat6;
    logic quiet;

    vecs[0]  = '{2'b00, 16'h8001, 4'd4,  16'h0800, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 16'h8001, 4'd15, 16'hC000, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 16'h4000, 4'd1,  16'h8000, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 16'h0003, 4'd2,  16'h000C, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 16'h1234, 4'd7,  16'h1234, 1'b0, 1'b1};
    vecs[5]  = '{2'b00, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 16'h0001, 4'd14, 16'h4000, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 16'h0001, 4'd15, 16'h8000, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 16'h1234, 4'd4,  16'h2341, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 16'hC000, 4'd1,  16'h8000, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 16'h8000, 4'd3,  16'h0000, 1'b1, 1'b0};
    vecs[12] = '{2'b01, 16'h0800, 4'd4,  16'h8000, 1'b1, 1'b0};
    vecs[13] = '{2'b01, 16'h0400, 4'd4,  16'h4000, 1'b0, 1'b0};
    vecs[14] = '{2'b10, 16'hFFFE, 4'd9,  16'hFDFF, 1'b0, 1'b0};
    vecs[15] = '{2'b11, 16'hBEEF, 4'd0,  16'hBEEF, 1'b0, 1'b1};

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check("por_busy", 32'(busy), 32'd0);
    check("por_done", 32'(done), 32'd0);
    check("por_out", 32'(Shift_Out), 32'h0);
    check("por_ovf", 32'(ovf), 32'd0);
    check("por_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].sin, vecs[i].sval,
             vecs[i].exp_out, vecs[i].exp_ovf, vecs[i].exp_err);
    end

    // Reset in the middle of a shift aborts the operation
    Shift_In  = 16'hFFFF;
    Shift_Val = 4'd10;
    Mode      = 2'b00;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_out", 32'(Shift_Out), 32'h0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("rst_no_late_done", 32'(quiet), 32'd1);
    $display("op reset_abort: quiet_after_release=%b out=%h", quiet, Shift_Out);
    @(posedge clk); #1;
    run_op("post_reset", 2'b00, 16'h8001, 4'd4, 16'h0800, 1'b0, 1'b0);

    // start re-pulsed while shifting and in DONE must be ignored
    lat6      = exp_lat(2'b00, 4'd10);
    Shift_In  = 16'hFFFF;
    Shift_Val = 4'd10;
    Mode      = 2'b00;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= lat6; c++) begin
      if (c == 2) begin
        start     = 1'b1;
        Mode      = 2'b11;
        Shift_In  = 16'h1234;
        Shift_Val = 4'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == lat6) begin
        check("ign_done", 32'(done), 32'd1);
        check("ign_out", 32'(Shift_Out), 32'h003F);
        check("ign_ovf", 32'(ovf), 32'd0);
        check("ign_err", 32'(err), 32'd0);
        $display("op ignore_start: SRL FFFF by 10 -> out=%h done=%b cycle=%0d", Shift_Out, done, c);
        // Request raised during DONE: it has to be dropped.
        start     = 1'b1;
        Mode      = 2'b01;
        Shift_In  = 16'h4000;
        Shift_Val = 4'd1;
      end else begin
        check($sformatf("ign_no_done_c%0d", c), 32'(done), 32'd0);
      end
      @(posedge clk); #1;
    end
    // Back-to-back: the cycle after done accepts a new request.
    run_op("back_to_back", 2'b01, 16'h4000, 4'd1, 16'h8000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
